// File: rtl/sram_block_ctrl_if.sv
// Cache-side block transfer handshake between the cache controller (master)
// and the SRAM block controller (slave).
interface sram_block_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 64
);
  logic              blk_req;
  logic              blk_we;
  logic [ADDR_W-1:0] blk_addr;
  logic [DATA_W-1:0] blk_wdata;
  logic [DATA_W-1:0] blk_rdata;
  logic              blk_ready;
  logic              busy;

  modport master (
    output blk_req, blk_we, blk_addr, blk_wdata,
    input  blk_rdata, blk_ready, busy
  );

  modport slave (
    input  blk_req, blk_we, blk_addr, blk_wdata,
    output blk_rdata, blk_ready, busy
  );
endinterface

// File: rtl/sram_block_ctrl.sv
// Turns one cache block fill or write-back into an asynchronous SRAM cycle.
// Optional: SRAM_CTRL_BUSTURN_EN inserts one dead bus cycle (TURN) after every write.
//
//  state    | meaning
//  IDLE     | strobes high, bus Z, accepts blk_req
//  RD       | CE/OE/LB/UB low for RD_CYCLES, data captured on the last edge
//  WR_SETUP | CE/LB/UB low, bus driven, WE high
//  WR_PULSE | as WR_SETUP with WE low for WR_CYCLES
//  WR_HOLD  | WE high again, bus and address still held
//  DONE     | strobes high, bus Z, blk_ready pulse
//  TURN     | (optional) dead cycle after a write, busy still high
module sram_block_ctrl #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 64,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_block_ctrl_if.slave  blk,
  output logic              ce_n_o,
  output logic              oe_n_o,
  output logic              we_n_o,
  output logic              lb_n_o,
  output logic              ub_n_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  inout  wire  [DATA_W-1:0] mem_data_io
);

  localparam int MAX_C = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
`ifdef SRAM_CTRL_BUSTURN_EN
    TURN     = 3'd6,
`endif
    DONE     = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               accept;
  logic               drive;
  logic               rd_last;
`ifdef SRAM_CTRL_BUSTURN_EN
  logic               we_q;
`endif

  assign accept  = (state_q == IDLE) && blk.blk_req;
  assign rd_last = (state_q == RD) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef SRAM_CTRL_BUSTURN_EN
      we_q    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        addr_q  <= blk.blk_addr;
        wdata_q <= blk.blk_wdata;
`ifdef SRAM_CTRL_BUSTURN_EN
        we_q    <= blk.blk_we;
`endif
      end
      if (rd_last) rdata_q <= mem_data_io;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
    case (state_q)
      IDLE:     if (blk.blk_req) state_d = blk.blk_we ? WR_SETUP : RD;
      RD:       if (cnt_q == '0) state_d = DONE;
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: if (cnt_q == '0) state_d = WR_HOLD;
      WR_HOLD:  state_d = DONE;
`ifdef SRAM_CTRL_BUSTURN_EN
      DONE:     state_d = we_q ? TURN : IDLE;
      TURN:     state_d = IDLE;
`else
      DONE:     state_d = IDLE;
`endif
      default:  state_d = IDLE;
    endcase
    // Timer reloads on every state entry; it only matters in RD and WR_PULSE.
    if (state_d != state_q) begin
      case (state_d)
        RD:       cnt_d = RD_LOAD;
        WR_PULSE: cnt_d = WR_LOAD;
        default:  cnt_d = '0;
      endcase
    end
  end

  always_comb begin
    ce_n_o        = 1'b1;
    oe_n_o        = 1'b1;
    we_n_o        = 1'b1;
    lb_n_o        = 1'b1;
    ub_n_o        = 1'b1;
    drive         = 1'b0;
    blk.blk_ready = 1'b0;
    case (state_q)
      RD: begin
        ce_n_o = 1'b0;
        oe_n_o = 1'b0;
        lb_n_o = 1'b0;
        ub_n_o = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        ce_n_o = 1'b0;
        lb_n_o = 1'b0;
        ub_n_o = 1'b0;
        drive  = 1'b1;
      end
      WR_PULSE: begin
        ce_n_o = 1'b0;
        we_n_o = 1'b0;
        lb_n_o = 1'b0;
        ub_n_o = 1'b0;
        drive  = 1'b1;
      end
      DONE:    blk.blk_ready = 1'b1;
      default: ;
    endcase
  end

  assign blk.busy      = (state_q != IDLE);
  assign blk.blk_rdata = rdata_q;
  assign mem_addr_o    = addr_q;
  assign mem_data_io   = drive ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_block_ctrl.sv
// Directed bench for sram_block_ctrl with a small behavioural SRAM on the data bus.
// Expected values are hand-computed for the default parameters.
module tb_sram_block_ctrl;

`ifdef SRAM_CTRL_BUSTURN_EN
  localparam int TURN_CYC = 1;
`else
  localparam int TURN_CYC = 0;
`endif

  localparam logic [63:0] D2 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] D4 = 64'h0008_0007_0006_0005;
  localparam logic [63:0] DA = 64'hA5A5_1234_5678_C3C3;

  logic        clk;
  logic        rst_n;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;
  logic [19:0] mem_addr;
  wire  [63:0] mem_data;

  int n_chk  = 0;
  int n_pass = 0;

  sram_block_ctrl_if #(.ADDR_W(20), .DATA_W(64)) bif ();

  sram_block_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .blk         (bif),
    .ce_n_o      (ce_n),
    .oe_n_o      (oe_n),
    .we_n_o      (we_n),
    .lb_n_o      (lb_n),
    .ub_n_o      (ub_n),
    .mem_addr_o  (mem_addr),
    .mem_data_io (mem_data)
  );

  // Behavioural SRAM: 32 words, index keeps the top address bit to expose aliasing.
  logic [63:0] sram [0:31];
  wire  [4:0]  sidx = {mem_addr[19], mem_addr[3:0]};
  assign mem_data = (!ce_n && !oe_n) ? sram[sidx] : 64'bz;

  always @(posedge clk) begin
    if (!ce_n && !we_n) sram[sidx] <= mem_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [19:0] a, input logic [63:0] d);
    int we_low = 0, drv = 0, rdy_at = 0;
    bit data_ok = 1, addr_ok = 1, excl_ok = 1, byte_ok = 1;
    bif.blk_req = 1'b1; bif.blk_we = 1'b1; bif.blk_addr = a; bif.blk_wdata = d;
    step();
    bif.blk_req = 1'b0; bif.blk_we = 1'b0; bif.blk_addr = ~a; bif.blk_wdata = ~d;
    for (int k = 1; k <= 8; k++) begin
      if (!we_n) we_low++;
      if (!ce_n && oe_n) begin
        drv++;
        if (mem_data !== d) data_ok = 0;
      end
      if (!ce_n && mem_addr !== a) addr_ok = 0;
      if (!we_n && (lb_n || ub_n)) byte_ok = 0;
      if (!oe_n && !we_n) excl_ok = 0;
      if (bif.blk_ready && rdy_at == 0) rdy_at = k;
      step();
    end
    chk("wr_we_low_cycles", 64'(we_low), 64'd2);
    chk("wr_bus_driven_cycles", 64'(drv), 64'd4);
    chk("wr_data_stable", 64'(data_ok), 64'd1);
    chk("wr_addr_stable", 64'(addr_ok), 64'd1);
    chk("wr_byte_lanes", 64'(byte_ok), 64'd1);
    chk("wr_oe_we_excl", 64'(excl_ok), 64'd1);
    chk("wr_latency", 64'(rdy_at), 64'd5);
  endtask

  task automatic do_read(input logic [19:0] a, input logic [63:0] d);
    int oe_low = 0, rdy_at = 0;
    bit addr_ok = 1;
    logic [63:0] rd_at_rdy = '0;
    bif.blk_req = 1'b1; bif.blk_we = 1'b0; bif.blk_addr = a; bif.blk_wdata = '0;
    step();
    bif.blk_req = 1'b0; bif.blk_we = 1'b1; bif.blk_addr = ~a;
    for (int k = 1; k <= 8; k++) begin
      if (!oe_n) oe_low++;
      if (!ce_n && mem_addr !== a) addr_ok = 0;
      if (bif.blk_ready && rdy_at == 0) begin
        rdy_at = k;
        rd_at_rdy = bif.blk_rdata;
      end
      step();
    end
    chk("rd_oe_low_cycles", 64'(oe_low), 64'd2);
    chk("rd_addr_stable", 64'(addr_ok), 64'd1);
    chk("rd_latency", 64'(rdy_at), 64'd3);
    chk("rd_data_at_ready", rd_at_rdy, d);
    chk("rd_data_held", bif.blk_rdata, d);
  endtask

  initial begin
    int r1, r2, rd_start, dead, idle;
    bit saw_rdy, a1_ok;
    logic [63:0] rd2;
    logic [19:0] rd2_addr;
    for (int i = 0; i < 32; i++) sram[i] = '0;
    rst_n = 1'b0;
    bif.blk_req = 1'b0; bif.blk_we = 1'b0; bif.blk_addr = '0; bif.blk_wdata = '0;
    repeat (3) step();

    chk("rst_strobes", 64'({ce_n, oe_n, we_n, lb_n, ub_n}), 64'h1F);
    chk("rst_busy", 64'(bif.busy), 64'd0);
    chk("rst_ready", 64'(bif.blk_ready), 64'd0);
    chk("rst_rdata", bif.blk_rdata, 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    rst_n = 1'b1;
    step();

    // Reset in the middle of a write pulse.
    bif.blk_req = 1'b1; bif.blk_we = 1'b1; bif.blk_addr = 20'h0000F; bif.blk_wdata = 64'hDEAD;
    step();
    bif.blk_req = 1'b0;
    step();
    chk("pre_rst_we_low", 64'(we_n), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_we_ce", 64'({we_n, ce_n, oe_n}), 64'h7);
    chk("midrst_busy", 64'(bif.busy), 64'd0);
    step();
    rst_n = 1'b1;
    saw_rdy = 0;
    for (int k = 0; k < 6; k++) begin
      if (bif.blk_ready) saw_rdy = 1;
      step();
    end
    chk("midrst_no_ready", 64'(saw_rdy), 64'd0);
    chk("midrst_idle", 64'(bif.busy), 64'd0);

    do_write(20'h00000, D2);
    do_read(20'h00000, D2);
    do_write(20'h80000, D4);
    do_read(20'h00000, D2);
    do_read(20'h80000, D4);

    // Request held high: write 0x00001, then a read of 0x00000 set up while busy.
    bif.blk_req = 1'b1; bif.blk_we = 1'b1; bif.blk_addr = 20'h00001; bif.blk_wdata = DA;
    step();
    bif.blk_we = 1'b0; bif.blk_addr = 20'h00000; bif.blk_wdata = 64'h0BAD_0BAD_0BAD_0BAD;
    r1 = 0; r2 = 0; rd_start = 0; dead = 0; idle = 0; a1_ok = 1;
    rd2 = '0; rd2_addr = '1;
    for (int k = 1; k <= 14; k++) begin
      if (k <= 4 && mem_addr !== 20'h00001) a1_ok = 0;
      if (!oe_n && rd_start == 0) begin
        rd_start = k;
        rd2_addr = mem_addr;
        bif.blk_req = 1'b0;
      end
      if (r1 != 0 && rd_start == 0) begin
        if (!bif.busy) idle++;
        else if (ce_n && oe_n && we_n) dead++;
      end
      if (bif.blk_ready) begin
        if (r1 == 0) r1 = k;
        else if (r2 == 0) begin
          r2 = k;
          rd2 = bif.blk_rdata;
        end
      end
      step();
    end
    bif.blk_req = 1'b0;
    chk("b2b_first_addr", 64'(a1_ok), 64'd1);
    chk("b2b_first_latency", 64'(r1), 64'd5);
    chk("b2b_turn_cycles", 64'(dead), 64'(TURN_CYC));
    chk("b2b_idle_cycles", 64'(idle), 64'd1);
    chk("b2b_second_addr", 64'(rd2_addr), 64'd0);
    chk("b2b_second_ready", 64'(r2), 64'(9 + TURN_CYC));
    chk("b2b_second_data", rd2, D2);
    do_read(20'h00001, DA);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
